llsc_monitor: RTL

Load-linked/store-conditional reservation controller for the core's memory stage. Tracks the linked address, clears the reservation on exceptions, ERET and snooped stores to the linked line, and sequences the store-conditional handshake toward the data memory. Drives the write port of the LL-bit register and returns the SC success/fail result to the writeback path.

---
 rtl/llsc_pkg.sv | 15 +
 rtl/llsc_timer.sv | 31 +++
 rtl/llsc_monitor.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/llsc_pkg.sv
// Shared types and default sizing for the LL/SC reservation monitor.
// Reservation FSM encoding plus default address width and granule.
package llsc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LINKED   = 2'd1,
    ST_SC_WAIT  = 2'd2,
    ST_SC_DRAIN = 2'd3
  } llsc_state_e;

  localparam int LLSC_ADDR_W   = 32;
  localparam int LLSC_GRAN_LSB = 2;

endpackage

// File: rtl/llsc_timer.sv
// Reservation lifetime down-counter; only built when LLSC_TIMEOUT_EN is defined.
// Reloads on every LL that (re)establishes the link, expires at zero while running.
module llsc_timer
  import llsc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = i_run && (r_cnt == '0);

endmodule

// File: rtl/llsc_monitor.sv
// LL/SC reservation controller: tracks the linked granule and sequences the SC store.
// Optional reservation timeout is enabled by defining LLSC_TIMEOUT_EN.
module llsc_monitor
  import llsc_pkg::*;
#(
  parameter int ADDR_W         = LLSC_ADDR_W,
  parameter int GRAN_LSB       = LLSC_GRAN_LSB,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_eret,
  input  logic              i_ll_req,
  input  logic [ADDR_W-1:0] i_ll_addr,
  input  logic              i_sc_req,
  input  logic [ADDR_W-1:0] i_sc_addr,
  input  logic              i_snoop_valid,
  input  logic [ADDR_W-1:0] i_snoop_addr,
  input  logic              i_mem_ack,
  output logic              o_mem_req,
  output logic              o_sc_busy,
  output logic              o_sc_done,
  output logic              o_sc_result,
  output logic              o_llbit_we,
  output logic              o_llbit_wd,
  output logic              o_link_valid
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("llsc_monitor: TIMEOUT_CYCLES must be at least 2");
  end

  llsc_state_e       r_state;
  llsc_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic              w_mem_req_nxt;
  logic              w_done_nxt;
  logic              w_result_nxt;
  logic              w_we_nxt;
  logic              w_wd_nxt;
  logic              w_sc_match;
  logic              w_snoop_hit;
  logic              w_expired;

  // Full address is kept so the granule compare can mask the low bits itself.
  assign w_sc_match  = (((i_sc_addr ^ r_addr) >> GRAN_LSB) == '0);
  assign w_snoop_hit = i_snoop_valid && (((i_snoop_addr ^ r_addr) >> GRAN_LSB) == '0);

`ifdef LLSC_TIMEOUT_EN
  logic w_tmr_load;

  // Staying in (or entering) LINKED with an LL present means that LL was taken.
  assign w_tmr_load = i_ll_req && (w_state_nxt == ST_LINKED);

  llsc_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_tmr_load),
    .i_run    (r_state == ST_LINKED),
    .o_expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_mem_req_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_result_nxt  = 1'b0;
    w_we_nxt      = 1'b0;
    w_wd_nxt      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!(i_flush || i_eret)) begin
          if (i_ll_req) begin
            w_state_nxt = ST_LINKED;
            w_addr_nxt  = i_ll_addr;
            w_we_nxt    = 1'b1;
            w_wd_nxt    = 1'b1;
          end else if (i_sc_req) begin
            w_done_nxt = 1'b1;
            w_we_nxt   = 1'b1;
          end
        end
      end
      ST_LINKED: begin
        if (i_flush || i_eret) begin
          w_state_nxt = ST_IDLE;
          w_we_nxt    = 1'b1;
        end else if (i_sc_req) begin
          if (w_sc_match && !w_snoop_hit) begin
            w_state_nxt   = ST_SC_WAIT;
            w_mem_req_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
            w_we_nxt    = 1'b1;
          end
        end else if (i_ll_req) begin
          w_addr_nxt = i_ll_addr;
          w_we_nxt   = 1'b1;
          w_wd_nxt   = 1'b1;
        end else if (w_snoop_hit || w_expired) begin
          w_state_nxt = ST_IDLE;
          w_we_nxt    = 1'b1;
        end
      end
      ST_SC_WAIT: begin
        // The store is committed once issued; snoops no longer matter here.
        if (i_mem_ack) begin
          w_state_nxt  = ST_IDLE;
          w_done_nxt   = !i_flush;
          w_result_nxt = !i_flush;
          w_we_nxt     = 1'b1;
        end else begin
          w_mem_req_nxt = 1'b1;
          if (i_flush) w_state_nxt = ST_SC_DRAIN;
        end
      end
      ST_SC_DRAIN: begin
        if (i_mem_ack) begin
          w_state_nxt = ST_IDLE;
          w_we_nxt    = 1'b1;
        end else begin
          w_mem_req_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      o_mem_req   <= 1'b0;
      o_sc_done   <= 1'b0;
      o_sc_result <= 1'b0;
      o_llbit_we  <= 1'b0;
      o_llbit_wd  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      o_mem_req   <= w_mem_req_nxt;
      o_sc_done   <= w_done_nxt;
      o_sc_result <= w_result_nxt;
      o_llbit_we  <= w_we_nxt;
      o_llbit_wd  <= w_wd_nxt;
    end
  end

  assign o_sc_busy    = (r_state == ST_SC_WAIT) || (r_state == ST_SC_DRAIN);
  assign o_link_valid = (r_state == ST_LINKED);

endmodule
